// File: rtl/hb_pkg.sv
// Shared constants, coefficients, FSM state type and tap-visit order for the
// time-multiplexed halfband. HB_SKIP_ZERO_TAPS_EN selects the nonzero-tap visit order.
package hb_pkg;

  localparam int WIDTH  = 18;
  localparam int LENGTH = 15;
  localparam int NTAPS  = (LENGTH + 1) / 2;
  localparam int ACC_W  = 40;

  // Output slice of the 2s34 accumulator that forms the 1s17 result
  localparam int Y_MSB = 2 * WIDTH - 2;
  localparam int Y_LSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  typedef logic [2:0] tap_t;

  localparam logic signed [WIDTH-1:0] HSYS [NTAPS] = '{
    -18'sd80, 18'sd0, 18'sd786, 18'sd0, -18'sd3924, 18'sd0, 18'sd19602, 18'sd32768
  };

  localparam tap_t TAP_SEQ_ALL  [NTAPS] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  localparam tap_t TAP_SEQ_SKIP [NTAPS] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7};

`ifdef HB_SKIP_ZERO_TAPS_EN
  localparam int   NVISIT = 5;
  localparam tap_t TAP_SEQ [NTAPS] = TAP_SEQ_SKIP;
`else
  localparam int   NVISIT = NTAPS;
  localparam tap_t TAP_SEQ [NTAPS] = TAP_SEQ_ALL;
`endif

  localparam tap_t VIS_LAST = tap_t'(NVISIT - 1);

  localparam logic signed [WIDTH-1:0] Y_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] Y_MIN = {1'b1, {(WIDTH-1){1'b0}}};

endpackage

// File: rtl/hb_mac_unit.sv
// Shared pre-adder and multiplier feeding one accumulator; one product per
// enabled cycle, cleared at the start of each output sample.
module hb_mac_unit
  import hb_pkg::*;
(
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     center,
  input  logic signed [WIDTH-1:0]  xa,
  input  logic signed [WIDTH-1:0]  xb,
  input  logic signed [WIDTH-1:0]  coef,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [WIDTH-1:0]   pre_p0;
  logic signed [2*WIDTH-1:0] prod_p0;
  logic signed [ACC_W-1:0]   acc_p1;

  // Stage p0: operands are 2s16, so the 18-bit pre-add cannot overflow
  always_comb begin
    pre_p0  = center ? xa : xa + xb;
    prod_p0 = pre_p0 * coef;
  end

  // Stage p1: accumulate the sign-extended 2s34 product
  always_ff @(posedge sys_clk) begin
    if (reset || clr) begin
      acc_p1 <= '0;
    end else if (en) begin
      acc_p1 <= acc_p1 + {{(ACC_W-2*WIDTH){prod_p0[2*WIDTH-1]}}, prod_p0};
    end
  end

  assign acc = acc_p1;

endmodule

// File: rtl/halfband_mac_sched.sv
// Time-multiplexed 15-tap symmetric halfband: FSM, delay line, tap sequencing
// and output saturation. HB_SKIP_ZERO_TAPS_EN (in hb_pkg) skips the zero taps.
module halfband_mac_sched
  import hb_pkg::*;
(
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     sam_clk_en,
  input  logic signed [WIDTH-1:0]  x_in,
  output logic signed [WIDTH-1:0]  y,
  output logic                     y_valid,
  output logic                     busy,
  output logic                     overrun
);

  state_t                   state;
  tap_t                     vis_idx;
  tap_t                     k_tap;
  logic [3:0]               mir_idx;
  logic                     accept;
  logic                     mac_en;
  logic                     center;
  logic signed [WIDTH-1:0]  x_dl [LENGTH];
  logic signed [WIDTH-1:0]  tap_a;
  logic signed [WIDTH-1:0]  tap_b;
  logic signed [WIDTH-1:0]  coef;
  logic signed [ACC_W-1:0]  acc;

  function automatic logic signed [WIDTH-1:0] sat_out(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-1-Y_MSB:0] top;
    top = a[ACC_W-1:Y_MSB];
    if (!((&top) || (~|top))) begin
      return a[ACC_W-1] ? Y_MIN : Y_MAX;
    end
    return a[Y_MSB:Y_LSB];
  endfunction

  always_comb begin
    accept  = sam_clk_en && (state == IDLE);
    mac_en  = (state == MAC);
    k_tap   = TAP_SEQ[vis_idx];
    mir_idx = 4'(LENGTH - 1) - {1'b0, k_tap};
    center  = (k_tap == tap_t'(NTAPS - 1));
    tap_a   = x_dl[k_tap];
    tap_b   = x_dl[mir_idx];
    coef    = HSYS[k_tap];
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int i = 0; i < LENGTH; i++) x_dl[i] <= '0;
    end else if (accept) begin
      x_dl[0] <= {x_in[WIDTH-1], x_in[WIDTH-1:1]};
      for (int i = 1; i < LENGTH; i++) x_dl[i] <= x_dl[i-1];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state   <= IDLE;
      vis_idx <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      overrun <= sam_clk_en && (state != IDLE);
      case (state)
        IDLE: begin
          if (sam_clk_en) begin
            state   <= MAC;
            vis_idx <= '0;
            busy    <= 1'b1;
          end
        end
        MAC: begin
          if (vis_idx == VIS_LAST) state <= DONE;
          else vis_idx <= vis_idx + 3'd1;
        end
        DONE: begin
          y       <= sat_out(acc);
          y_valid <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  hb_mac_unit u_mac (
    .sys_clk (sys_clk),
    .reset   (reset),
    .clr     (accept),
    .en      (mac_en),
    .center  (center),
    .xa      (tap_a),
    .xb      (tap_b),
    .coef    (coef),
    .acc     (acc)
  );

endmodule

// File: tb/tb_halfband_mac_sched.sv
// Directed bench for halfband_mac_sched: cycle-level expectation of y/y_valid/
// busy/overrun with a direct-form 15-tap reference and hand-computed vectors.
module tb_halfband_mac_sched;

`ifdef HB_SKIP_ZERO_TAPS_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 10;
`endif
  localparam int NOH = 32'h7fff_ffff;

  logic               sys_clk;
  logic               reset;
  logic               sam_clk_en;
  logic signed [17:0] x_in;
  logic signed [17:0] y;
  logic               y_valid;
  logic               busy;
  logic               overrun;

  halfband_mac_sched dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .sam_clk_en (sam_clk_en),
    .x_in       (x_in),
    .y          (y),
    .y_valid    (y_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int H15 [15] = '{-80, 0, 786, 0, -3924, 0, 19602, 32768, 19602, 0, -3924, 0, 786, 0, -80};
  int IMP [15] = '{-20, 0, 196, 0, -981, 0, 4900, 8192, 4900, 0, -981, 0, 196, 0, -20};

  longint md [15];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     free_at = 0;
  int     last_acc = -100;
  int     ov_due = -1;
  int     exp_y = 0;
  int     due_cyc [$];
  int     due_y [$];
  int     due_hand [$];

  function automatic int model_push(input logic signed [17:0] xs);
    longint acc;
    acc = 0;
    for (int i = 14; i > 0; i--) md[i] = md[i-1];
    md[0] = longint'(xs) >>> 1;
    for (int i = 0; i < 15; i++) acc += longint'(H15[i]) * md[i];
    acc = acc >>> 17;
    if (acc > 131071) return 131071;
    if (acc < -131072) return -131072;
    return int'(acc);
  endfunction

  // One sys_clk cycle: drive inputs, update expectations, then check outputs
  task automatic step(input bit rst, input bit stb, input logic signed [17:0] xs, input int hand);
    bit exp_v;
    int h;
    reset      = rst;
    sam_clk_en = stb;
    x_in       = xs;
    if (!rst && stb) begin
      if (cyc >= free_at) begin
        due_cyc.push_back(cyc + LAT);
        due_y.push_back(model_push(xs));
        due_hand.push_back(hand);
        last_acc = cyc;
        free_at  = cyc + LAT;
      end else begin
        ov_due = cyc + 1;
      end
    end
    @(posedge sys_clk);
    #1;
    cyc++;
    reset      = 1'b0;
    sam_clk_en = 1'b0;
    if (rst) begin
      for (int i = 0; i < 15; i++) md[i] = 0;
      due_cyc.delete();
      due_y.delete();
      due_hand.delete();
      exp_y    = 0;
      free_at  = cyc;
      last_acc = -100;
      ov_due   = -1;
    end
    h = NOH;
    exp_v = (due_cyc.size() != 0) && (due_cyc[0] == cyc);
    if (exp_v) begin
      void'(due_cyc.pop_front());
      exp_y = due_y.pop_front();
      h     = due_hand.pop_front();
    end
    total++;
    assert (y_valid === exp_v) else begin
      bad++; $error("FAIL y_valid cyc=%0d got=%b exp=%b", cyc, y_valid, exp_v);
    end
    total++;
    assert (y === 18'(exp_y)) else begin
      bad++; $error("FAIL y cyc=%0d got=%0d exp=%0d", cyc, y, exp_y);
    end
    total++;
    assert (busy === ((cyc > last_acc) && (cyc < free_at))) else begin
      bad++; $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, (cyc > last_acc) && (cyc < free_at));
    end
    total++;
    assert (overrun === (cyc == ov_due)) else begin
      bad++; $error("FAIL overrun cyc=%0d got=%b exp=%b", cyc, overrun, cyc == ov_due);
    end
    if (h != NOH) begin
      total++;
      assert (y === 18'(h)) else begin
        bad++; $error("FAIL y_hand cyc=%0d got=%0d exp=%0d", cyc, y, h);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, NOH);
  endtask

  task automatic impulse_run(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, (i == 0) ? 18'sd65536 : 18'sd0, IMP[i]);
      idle(11);
    end
  endtask

  initial begin
    logic signed [17:0] r;
    reset      = 1'b1;
    sam_clk_en = 1'b0;
    x_in       = '0;

    // Reset state
    step(1'b1, 1'b0, '0, NOH);
    step(1'b1, 1'b0, '0, NOH);
    idle(3);

    // Impulse response at spacing 12
    impulse_run(15);
    idle(LAT + 2);

    // Reset in the middle of the MAC sequence, then impulse from zero
    step(1'b0, 1'b1, 18'sd65536, NOH);
    idle(3);
    step(1'b1, 1'b0, '0, NOH);
    idle(2);
    impulse_run(3);

    // Strobe coincident with reset is discarded
    step(1'b1, 1'b1, 18'sd65536, NOH);
    step(1'b0, 1'b1, 18'sd0, 0);
    idle(LAT + 2);

    // Negative full-scale DC at minimum spacing
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 18'h20000, (i >= 15) ? -32768 : NOH);
      idle(LAT - 1);
    end
    // Full-scale alternating
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, (i % 2 == 1) ? 18'h20000 : 18'h1FFFF, (i >= 15) ? -1 : NOH);
      idle(LAT - 1);
    end
    // Positive full-scale DC
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 18'h1FFFF, (i >= 15) ? 32767 : NOH);
      idle(LAT - 1);
    end
    idle(LAT + 2);

    // Overrun: spacing 9, then spacing one below minimum
    for (int i = 0; i < 12; i++) begin
      r = 18'($urandom);
      step(1'b0, 1'b1, r, NOH);
      idle(8);
    end
    for (int i = 0; i < 12; i++) begin
      r = 18'($urandom);
      step(1'b0, 1'b1, r, NOH);
      idle(LAT - 2);
    end
    idle(LAT + 2);

    // Random samples at spacing 10
    for (int i = 0; i < 1000; i++) begin
      r = 18'($urandom);
      step(1'b0, 1'b1, r, NOH);
      idle(9);
    end
    idle(LAT + 2);

    total++;
    assert (due_cyc.size() == 0) else begin
      bad++; $error("FAIL drain pending=%0d exp=0", due_cyc.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
